button_seq_fsm: RTL and testbench

BUTTON_SEQ_FSM -- requirements
Module: button_seq_fsm

---
 rtl/button_seq_pkg.sv | 21 ++
 rtl/press_detect.sv | 29 ++
 rtl/button_seq_fsm.sv | 172 +++++++++++++++++
 tb/tb_button_seq_fsm.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/button_seq_pkg.sv
// Shared state encoding and small elaboration helpers for the button sequence lock.
package button_seq_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_MATCH   = 3'd2,
    ST_FAIL    = 3'd3,
    ST_LOCKOUT = 3'd4
  } state_e;

  // Largest of the three durations sharing the single cycle counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/press_detect.sv
// Two-stage button sampler; a press is the first nonzero sample after an all-zero one.
module press_detect #(
  parameter int NB = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [NB:1] b,
  output logic        press,
  output logic [NB:1] symbol
);

  logic [NB:1] b_q;
  logic [NB:1] b_q2;

  // All-ones reset so a button held through reset release is not seen as a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_q  <= '1;
      b_q2 <= '1;
    end else begin
      b_q  <= b;
      b_q2 <= b_q;
    end
  end

  assign press  = (b_q != '0) && (b_q2 == '0);
  assign symbol = b_q;

endmodule

// File: rtl/button_seq_fsm.sv
// Code-lock FSM: matches a sequence of button presses, holds outp on success and
// locks out after MAX_FAIL consecutive failures.
module button_seq_fsm
  import button_seq_pkg::*;
#(
  parameter int                       NB       = 3,
  parameter int                       SEQ_LEN  = 4,
  parameter logic [NB*SEQ_LEN-1:0]    SEQ_CODE = {3'h6, 3'h5, 3'h2, 3'h1},
  parameter int                       TIMEOUT  = 16,
  parameter int                       HOLD_CYC = 8,
  parameter int                       MAX_FAIL = 3,
  parameter int                       LOCK_CYC = 32
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NB:1]                        b,
  output logic                               outp,
  output logic                               locked,
  output logic [$clog2(MAX_FAIL+1)-1:0]      fail_cnt,
  output logic [STATE_W-1:0]                 state_o
);

  localparam int CNT_MAX = max3(TIMEOUT, HOLD_CYC, LOCK_CYC);
  localparam int CW      = $clog2(CNT_MAX);
  localparam int IW      = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
  localparam int FW      = $clog2(MAX_FAIL + 1);

  localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_CYC - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(SEQ_LEN - 1);
  localparam logic [FW-1:0] FAIL_MAX  = FW'(MAX_FAIL);

  if (NB < 1 || NB > 8) begin : g_bad_nb
    $error("button_seq_fsm: NB must be in 1..8");
  end
  if (SEQ_LEN < 1 || SEQ_LEN > 16) begin : g_bad_len
    $error("button_seq_fsm: SEQ_LEN must be in 1..16");
  end
  if (TIMEOUT < 2) begin : g_bad_to
    $error("button_seq_fsm: TIMEOUT must be at least 2");
  end
  if (HOLD_CYC < 1 || MAX_FAIL < 1 || LOCK_CYC < 1) begin : g_bad_cyc
    $error("button_seq_fsm: HOLD_CYC, MAX_FAIL and LOCK_CYC must be at least 1");
  end

  // Unpack the code into a table indexed by sequence position.
  logic [NB:1] code_tbl [SEQ_LEN];
  for (genvar k = 0; k < SEQ_LEN; k++) begin : g_code
    if (SEQ_CODE[k*NB +: NB] == '0) begin : g_zero
      $error("button_seq_fsm: every SEQ_CODE element must be nonzero");
    end
    assign code_tbl[k] = SEQ_CODE[k*NB +: NB];
  end

  logic        press;
  logic [NB:1] symbol;

  press_detect #(.NB(NB)) u_press_detect (
    .clk    (clk),
    .rst_n  (rst_n),
    .b      (b),
    .press  (press),
    .symbol (symbol)
  );

  state_e        state, state_n;
  logic [IW-1:0] idx, idx_n;
  logic [CW-1:0] timer, timer_n;
  logic [FW-1:0] fail_n;
  logic [FW-1:0] fail_inc;

  assign fail_inc = (fail_cnt == FAIL_MAX) ? fail_cnt : fail_cnt + FW'(1);

  always_comb begin
    state_n = state;
    idx_n   = idx;
    timer_n = timer;
    fail_n  = fail_cnt;
    case (state)
      ST_IDLE: begin
        idx_n   = '0;
        timer_n = '0;
        if (press) begin
          if (symbol != code_tbl[0]) begin
            state_n = ST_FAIL;
            fail_n  = fail_inc;
          end else if (SEQ_LEN == 1) begin
            state_n = ST_MATCH;
            fail_n  = '0;
          end else begin
            state_n = ST_COLLECT;
            idx_n   = IW'(1);
          end
        end
      end
      ST_COLLECT: begin
        // A press in the last timeout cycle wins over the timeout.
        if (press) begin
          timer_n = '0;
          if (symbol != code_tbl[idx]) begin
            state_n = ST_FAIL;
            idx_n   = '0;
            fail_n  = fail_inc;
          end else if (idx == IDX_LAST) begin
            state_n = ST_MATCH;
            idx_n   = '0;
            fail_n  = '0;
          end else begin
            idx_n = idx + IW'(1);
          end
        end else if (timer == TO_LAST) begin
          state_n = ST_FAIL;
          idx_n   = '0;
          timer_n = '0;
          fail_n  = fail_inc;
        end else begin
          timer_n = timer + CW'(1);
        end
      end
      ST_MATCH: begin
        if (timer == HOLD_LAST) begin
          state_n = ST_IDLE;
          timer_n = '0;
        end else begin
          timer_n = timer + CW'(1);
        end
      end
      ST_FAIL: begin
        idx_n   = '0;
        timer_n = '0;
        state_n = (fail_cnt == FAIL_MAX) ? ST_LOCKOUT : ST_IDLE;
      end
      ST_LOCKOUT: begin
        if (timer == LOCK_LAST) begin
          state_n = ST_IDLE;
          timer_n = '0;
          fail_n  = '0;
        end else begin
          timer_n = timer + CW'(1);
        end
      end
      default: begin
        state_n = ST_IDLE;
        idx_n   = '0;
        timer_n = '0;
      end
    endcase
  end

  // outp/locked are registered from the next state so they track state_o exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      idx      <= '0;
      timer    <= '0;
      fail_cnt <= '0;
      outp     <= 1'b0;
      locked   <= 1'b0;
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      timer    <= timer_n;
      fail_cnt <= fail_n;
      outp     <= (state_n == ST_MATCH);
      locked   <= (state_n == ST_LOCKOUT);
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_button_seq_fsm.sv
// Directed bench for button_seq_fsm with default parameters.
module tb_button_seq_fsm;

  logic       clk;
  logic       rst_n;
  logic [3:1] b;
  logic       outp;
  logic       locked;
  logic [1:0] fail_cnt;
  logic [2:0] state_o;

  int total = 0;
  int bad   = 0;

  int outp_cyc = 0;
  int lock_cyc = 0;
  int fail_cyc = 0;

  button_seq_fsm dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .b        (b),
    .outp     (outp),
    .locked   (locked),
    .fail_cnt (fail_cnt),
    .state_o  (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (outp)           outp_cyc++;
    if (locked)         lock_cyc++;
    if (state_o == 3'd3) fail_cyc++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    b     = '0;
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic push(input logic [3:1] sym, input int hold, input int gap);
    b = sym;
    tick(hold);
    b = '0;
    tick(gap);
  endtask

  initial begin
    #1000000;
    bad++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int o0, l0, f0;
    b     = '0;
    rst_n = 1'b0;
    tick(2);
    check("rst_state", state_o, 0);
    check("rst_outp", outp, 0);
    check("rst_locked", locked, 0);
    check("rst_fail_cnt", fail_cnt, 0);
    rst_n = 1'b1;
    tick(2);

    // Full match 1,2,5,6 with latency and hold length.
    do_reset();
    o0 = outp_cyc; f0 = fail_cyc;
    push(3'd1, 3, 2);
    push(3'd2, 3, 2);
    push(3'd5, 3, 2);
    b = 3'd6;
    tick(1);
    check("match_lat_early", outp, 0);
    tick(1);
    check("match_lat_outp", outp, 1);
    check("match_state", state_o, 2);
    tick(1);
    b = '0;
    tick(6);
    check("match_hold_last", outp, 1);
    tick(1);
    check("match_end_outp", outp, 0);
    check("match_end_state", state_o, 0);
    tick(4);
    check("match_outp_cycles", outp_cyc - o0, 8);
    check("match_fail_cnt", fail_cnt, 0);
    check("match_no_fail", fail_cyc - f0, 0);

    // Wrong third symbol.
    do_reset();
    o0 = outp_cyc; f0 = fail_cyc;
    push(3'd1, 3, 2);
    push(3'd2, 3, 2);
    b = 3'd3;
    tick(2);
    check("bad3_state_fail", state_o, 3);
    check("bad3_fail_cnt", fail_cnt, 1);
    tick(1);
    check("bad3_back_idle", state_o, 0);
    b = '0;
    tick(3);
    check("bad3_fail_cycles", fail_cyc - f0, 1);
    check("bad3_no_outp", outp_cyc - o0, 0);
    check("bad3_fail_cnt_hold", fail_cnt, 1);

    // Timeout after first symbol.
    do_reset();
    b = 3'd1;
    tick(3);
    b = '0;
    tick(13);
    check("to_t14_state", state_o, 1);
    tick(1);
    check("to_t15_state", state_o, 1);
    tick(1);
    check("to_fail_state", state_o, 3);
    check("to_fail_cnt", fail_cnt, 1);
    tick(1);
    check("to_idle_state", state_o, 0);

    // Lockout after three wrong first presses.
    do_reset();
    l0 = lock_cyc; o0 = outp_cyc;
    push(3'd4, 3, 2);
    check("lk_cnt1", fail_cnt, 1);
    push(3'd4, 3, 2);
    check("lk_cnt2", fail_cnt, 2);
    b = 3'd4;
    tick(2);
    check("lk_fail_state", state_o, 3);
    check("lk_fail_cnt3", fail_cnt, 3);
    tick(1);
    check("lk_locked", locked, 1);
    check("lk_state", state_o, 4);
    b = '0;
    push(3'd1, 3, 2);
    push(3'd2, 3, 2);
    push(3'd5, 3, 2);
    push(3'd6, 3, 2);
    check("lk_still_locked", locked, 1);
    check("lk_no_outp", outp_cyc - o0, 0);
    tick(11);
    check("lk_last_cycle", locked, 1);
    tick(1);
    check("lk_released", locked, 0);
    check("lk_idle", state_o, 0);
    check("lk_fail_cleared", fail_cnt, 0);
    check("lk_cycles", lock_cyc - l0, 32);
    push(3'd1, 3, 2);
    push(3'd2, 3, 2);
    push(3'd5, 3, 2);
    push(3'd6, 3, 12);
    check("lk_then_match", outp_cyc - o0, 8);

    // Button held through reset release.
    b     = 3'd1;
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(3);
    check("held_rst_no_press", state_o, 0);
    b = '0;
    tick(2);
    check("held_rst_idle", state_o, 0);
    b = 3'd1;
    tick(2);
    check("held_rst_then_press", state_o, 1);

    // Reset in the middle of MATCH.
    do_reset();
    push(3'd1, 3, 2);
    push(3'd2, 3, 2);
    push(3'd5, 3, 2);
    b = 3'd6;
    tick(3);
    check("midm_in_match", outp, 1);
    rst_n = 1'b0;
    #1;
    check("midm_async_outp", outp, 0);
    check("midm_async_state", state_o, 0);
    b = '0;
    tick(1);
    rst_n = 1'b1;
    tick(3);
    check("midm_stays_idle", state_o, 0);

    // Nonzero-to-nonzero change is not a second press.
    do_reset();
    o0 = outp_cyc; f0 = fail_cyc;
    b = 3'd1;
    tick(3);
    b = 3'd3;
    tick(3);
    b = '0;
    tick(2);
    check("slide_collect", state_o, 1);
    check("slide_no_fail", fail_cyc - f0, 0);
    push(3'd2, 3, 2);
    push(3'd5, 3, 2);
    push(3'd6, 3, 12);
    check("slide_idx_kept", outp_cyc - o0, 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
